// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and constants for the 7-segment output driver
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } state_t;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam int         DP_BIT    = 7;

  localparam logic [2:0] DIGIT_UNITS    = 3'b001;
  localparam logic [2:0] DIGIT_TENS     = 3'b010;
  localparam logic [2:0] DIGIT_HUNDREDS = 3'b100;

  // Two's-complement magnitude; -128 maps to 128 in the unsigned 8-bit result.
  function automatic logic [7:0] magnitude(input logic [7:0] v, input logic is_signed);
    return (is_signed && v[7]) ? (~v + 8'd1) : v;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - BCD digit to segment pattern with blanking and decimal point
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] glyph;

  always_comb begin
    glyph = SEG_BLANK;
    case (bcd)
      4'd0: glyph = SEG_0;
      4'd1: glyph = SEG_1;
      4'd2: glyph = SEG_2;
      4'd3: glyph = SEG_3;
      4'd4: glyph = SEG_4;
      4'd5: glyph = SEG_5;
      4'd6: glyph = SEG_6;
      4'd7: glyph = SEG_7;
      4'd8: glyph = SEG_8;
      4'd9: glyph = SEG_9;
      default: glyph = SEG_BLANK;
    endcase
    seg = blank ? SEG_BLANK : glyph;
    seg[DP_BIT] = dp;
  end

endmodule

// File: rtl/seg7_out_driver.sv
// rtl/seg7_out_driver.sv - byte to 3-digit multiplexed display via sequential double-dabble
module seg7_out_driver
  import seg7_pkg::*;
#(
  parameter logic [23:0] REFRESH_COUNT = 24'd10_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value,
  input  logic       load,
  input  logic       mode_signed,
  output logic [7:0] seg,
  output logic [2:0] digit_en,
  output logic       busy
);

  state_t      state, state_next;
  logic [7:0]  bin;
  logic [11:0] bcd, bcd_adj;
  logic [3:0]  iter;
  logic        neg_work;
  logic        pend_valid;
  logic [7:0]  pend_value;
  logic        pend_signed;
  logic [11:0] disp_bcd;
  logic        disp_neg;
  logic [23:0] refresh_cnt;

  logic        start;
  logic [7:0]  src_value;
  logic        src_signed;
  logic [3:0]  mux_bcd;
  logic        mux_blank;
  logic        mux_dp;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
  end

  // A load arriving in the COMMIT cycle takes priority over the stored pending value.
  always_comb begin
    src_value  = value;
    src_signed = mode_signed;
    if (state == COMMIT && !load) begin
      src_value  = pend_value;
      src_signed = pend_signed;
    end
    start = (state == IDLE && load) || (state == COMMIT && (load || pend_valid));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = CONVERT;
      CONVERT: if (iter == 4'd7) state_next = COMMIT;
      COMMIT:  state_next = (load || pend_valid) ? CONVERT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bin         <= 8'd0;
      bcd         <= 12'd0;
      iter        <= 4'd0;
      neg_work    <= 1'b0;
      pend_valid  <= 1'b0;
      pend_value  <= 8'd0;
      pend_signed <= 1'b0;
      disp_bcd    <= 12'd0;
      disp_neg    <= 1'b0;
    end else begin
      state <= state_next;
      if (state == CONVERT) begin
        {bcd, bin} <= {bcd_adj, bin} << 1;
        iter       <= iter + 4'd1;
        if (load) begin
          pend_valid  <= 1'b1;
          pend_value  <= value;
          pend_signed <= mode_signed;
        end
      end
      if (state == COMMIT) begin
        disp_bcd   <= bcd;
        disp_neg   <= neg_work;
        pend_valid <= 1'b0;
      end
      if (start) begin
        bin      <= magnitude(src_value, src_signed);
        neg_work <= src_signed && src_value[7];
        bcd      <= 12'd0;
        iter     <= 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= 24'd0;
      digit_en    <= DIGIT_UNITS;
    end else if (refresh_cnt == REFRESH_COUNT - 24'd1) begin
      refresh_cnt <= 24'd0;
      digit_en    <= {digit_en[1:0], digit_en[2]};
    end else begin
      refresh_cnt <= refresh_cnt + 24'd1;
    end
  end

  // Leading-zero suppression: tens blanks only when hundreds is also zero.
  always_comb begin
    mux_bcd   = disp_bcd[3:0];
    mux_blank = 1'b0;
    mux_dp    = 1'b0;
    case (digit_en)
      DIGIT_TENS: begin
        mux_bcd   = disp_bcd[7:4];
        mux_blank = (disp_bcd[11:4] == 8'd0);
      end
      DIGIT_HUNDREDS: begin
        mux_bcd   = disp_bcd[11:8];
        mux_blank = (disp_bcd[11:8] == 4'd0);
        mux_dp    = disp_neg;
      end
      default: ;
    endcase
  end

  seg7_decode u_decode (
    .bcd   (mux_bcd),
    .blank (mux_blank),
    .dp    (mux_dp),
    .seg   (seg)
  );

  assign busy = (state != IDLE);

endmodule
